// File: rtl/dm_cache_param.sv
// Direct-mapped write-back/write-allocate cache; hit completes 2 cycles after cpu_valid, misses add fill and write-back waits.
// Requests are accepted only in IDLE (cpu_* ignored until cpu_ready); the memory side holds mem_* stable until mem_ack.
module dm_cache_param #(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_LINES      = 1024,
  parameter int CNT_W          = 16,
  localparam int OFF_W  = $clog2(WORDS_PER_LINE),
  localparam int IDX_W  = $clog2(NUM_LINES),
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W,
  localparam int LINE_W = DATA_W * WORDS_PER_LINE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_valid,
  input  logic                    cpu_rw,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_ready,
  output logic [DATA_W-1:0]       cpu_rdata,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [LINE_W-1:0]       mem_wdata,
  input  logic [LINE_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_COMPARE    = 3'd1;
  localparam logic [2:0] S_WRITE_BACK = 3'd2;
  localparam logic [2:0] S_ALLOCATE   = 3'd3;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd4;
  localparam logic [2:0] S_FLUSH_WB   = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  logic [2:0]              state;
  logic [ADDR_W-1:0]       req_addr;
  logic                    req_rw;
  logic [DATA_W-1:0]       req_wdata;
  logic                    refill;
  logic [IDX_W-1:0]        scan_idx;
  logic [NUM_LINES-1:0]    valid_q;
  logic [NUM_LINES-1:0]    dirty_q;

  logic [TAG_W-1:0]                       tag_mem  [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]  data_mem [NUM_LINES];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             hit;
  logic             ack_ok;

  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];
  assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign ack_ok  = mem_req && mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      flush_done <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      req_addr   <= '0;
      req_rw     <= 1'b0;
      req_wdata  <= '0;
      refill     <= 1'b0;
      scan_idx   <= '0;
    end else begin
      cpu_ready  <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush) begin
            scan_idx <= '0;
            state    <= S_FLUSH_SCAN;
          end else if (cpu_valid) begin
            req_addr  <= cpu_addr;
            req_rw    <= cpu_rw;
            req_wdata <= cpu_wdata;
            refill    <= 1'b0;
            state     <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            state     <= S_IDLE;
            if (req_rw) dirty_q[req_idx] <= 1'b1;
            else        cpu_rdata <= data_mem[req_idx][req_off];
            // the re-compare after a fill is the tail of a miss, not a hit
            if (!refill && hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
          end else begin
            if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_W'(1);
            mem_req <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[req_idx], req_idx};
              mem_wdata <= data_mem[req_idx];
              state     <= S_WRITE_BACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_idx};
              state    <= S_ALLOCATE;
            end
          end
        end
        S_WRITE_BACK: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          // entered with mem_req low after a write-back: open the fill one cycle later
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_idx};
          end else if (mem_ack) begin
            mem_req          <= 1'b0;
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
            refill           <= 1'b1;
            state            <= S_COMPARE;
          end
        end
        S_FLUSH_SCAN: begin
          if (valid_q[scan_idx] && dirty_q[scan_idx]) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_mem[scan_idx], scan_idx};
            mem_wdata <= data_mem[scan_idx];
            state     <= S_FLUSH_WB;
          end else if (scan_idx == LAST_IDX) begin
            flush_done <= 1'b1;
            state      <= S_IDLE;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        S_FLUSH_WB: begin
          if (ack_ok) begin
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            dirty_q[scan_idx] <= 1'b0;
            if (scan_idx == LAST_IDX) begin
              flush_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              scan_idx <= scan_idx + IDX_W'(1);
              state    <= S_FLUSH_SCAN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // tag/data storage carries no reset; valid_q guards its contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_ALLOCATE && ack_ok) begin
        data_mem[req_idx] <= mem_rdata;
        tag_mem[req_idx]  <= req_tag;
      end else if (state == S_COMPARE && hit && req_rw) begin
        data_mem[req_idx][req_off] <= req_wdata;
      end
    end
  end

endmodule
